// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the memory bus responder.
//   - state_e     : responder FSM states
//   - DefDataW    : default data bus width
//   - DefAddrW    : default address bus width
//   - DefRamBase  : default first address of the RAM window
//   - MaxWait     : largest supported wait-state count
package mem_bus_pkg;

    localparam int unsigned DefDataW   = 8;
    localparam int unsigned DefAddrW   = 8;
    localparam logic [7:0]  DefRamBase = 8'h80;
    localparam int unsigned MaxWait    = 3;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRdrive,
        StWdone,
        StErr
    } state_e;

endpackage

// File: rtl/mem_bus_ram_array.sv
// mem_bus_ram_array: DEPTH x DATA_W storage, no reset (contents survive rst).
//   clk_i   : write clock
//   we_i    : write enable, array updated on rising edge
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : read word address
//   rdata_o : combinational read data
module mem_bus_ram_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 128,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: responder end of the processor memory bus for the RAM window
// RAM_BASE..RAM_BASE+DEPTH-1, with wait states, ready handshake, error detection
// and a completed-access counter.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   MAddr      : bus address
//   MData      : shared data bus, driven only while a read is completing
//   ram_en_bar : RAM select, active-low
//   re_bar     : read strobe, active-low
//   we_bar     : write strobe, active-low
//   mem_rdy    : read data valid / write committed
//   bus_err    : one-cycle pulse on a request with both strobes low
//   access_cnt : completed in-window accesses, wraps
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned       DATA_W      = DefDataW,
    parameter int unsigned       ADDR_W      = DefAddrW,
    parameter int unsigned       DEPTH       = 128,
    parameter logic [ADDR_W-1:0] RAM_BASE    = ADDR_W'(DefRamBase),
    parameter int unsigned       WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] MAddr,
    inout  wire  [DATA_W-1:0] MData,
    input  logic              ram_en_bar,
    input  logic              re_bar,
    input  logic              we_bar,
    output logic              mem_rdy,
    output logic              bus_err,
    output logic [7:0]        access_cnt
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Out-of-range settings saturate to the deepest supported wait.
    localparam int unsigned WaitEff = (WAIT_STATES > MaxWait) ? MaxWait : WAIT_STATES;
    localparam int unsigned WinLo   = 32'(RAM_BASE);
    localparam int unsigned WinHi   = WinLo + DEPTH;

    state_e            state_q, state_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              dir_wr_q, dir_wr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_rdy_q, mem_rdy_d;
    logic              bus_err_q, bus_err_d;

    logic              in_window, req, strobe_off, oe;
    logic [AW-1:0]     offset;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    assign in_window  = (32'(MAddr) >= WinLo) && (32'(MAddr) < WinHi);
    assign req        = ~ram_en_bar & in_window;
    assign offset     = AW'(MAddr - RAM_BASE);
    // Release of the strobe belonging to the captured direction ends the access.
    assign strobe_off = dir_wr_q ? we_bar : re_bar;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        dir_wr_d   = dir_wr_q;
        cnt_d      = cnt_q;
        ram_we     = 1'b0;
        ram_waddr  = addr_q;
        ram_wdata  = data_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (!re_bar && !we_bar) begin
                        state_d = StErr;
                    end else if (!re_bar || !we_bar) begin
                        dir_wr_d = ~we_bar;
                        addr_d   = offset;
                        data_d   = MData;
                        if (WaitEff > 0) begin
                            state_d    = StWait;
                            wait_cnt_d = 2'(WaitEff - 1);
                        end else if (!we_bar) begin
                            state_d   = StWdone;
                            ram_we    = 1'b1;
                            ram_waddr = offset;
                            ram_wdata = MData;
                        end else begin
                            state_d = StRdrive;
                        end
                    end
                end
            end
            StWait: begin
                if (ram_en_bar || strobe_off) begin
                    state_d = StIdle;  // aborted: nothing written, nothing counted
                end else if (wait_cnt_q == 2'd0) begin
                    if (dir_wr_q) begin
                        state_d = StWdone;
                        ram_we  = 1'b1;
                    end else begin
                        state_d = StRdrive;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            StRdrive, StWdone: begin
                if (ram_en_bar || strobe_off) begin
                    state_d = StIdle;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            StErr: begin
                // Wait for both strobes so a still-held one cannot start an access.
                if (ram_en_bar || (re_bar && we_bar)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        mem_rdy_d = (state_d == StRdrive) || (state_d == StWdone);
        bus_err_d = (state_q == StIdle) && (state_d == StErr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            dir_wr_q   <= 1'b0;
            cnt_q      <= 8'd0;
            mem_rdy_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            dir_wr_q   <= dir_wr_d;
            cnt_q      <= cnt_d;
            mem_rdy_q  <= mem_rdy_d;
            bus_err_q  <= bus_err_d;
        end
    end

    mem_bus_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (addr_q),
        .rdata_o (ram_rdata)
    );

    // Bus is let go the moment the processor drops select or the read strobe.
    assign oe         = (state_q == StRdrive) & ~ram_en_bar & ~re_bar;
    assign MData      = oe ? ram_rdata : {DATA_W{1'bz}};
    assign mem_rdy    = mem_rdy_q;
    assign bus_err    = bus_err_q;
    assign access_cnt = cnt_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] maddr;
    logic       re_bar, we_bar, en0_bar, en1_bar;
    logic       wr_oe;
    logic [7:0] wr_data;
    tri1  [7:0] md0, md1;  // undriven bus reads back as 8'hFF
    logic       rdy0, rdy1, err0, err1;
    logic [7:0] cnt0, cnt1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model0 [256];
    logic [7:0] model1 [256];
    logic [7:0] cnt_exp0, cnt_exp1;

    assign md0 = wr_oe ? wr_data : 8'hzz;
    assign md1 = wr_oe ? wr_data : 8'hzz;

    always #5 clk = ~clk;

    mem_bus_responder #(
        .WAIT_STATES (1)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .MAddr      (maddr),
        .MData      (md0),
        .ram_en_bar (en0_bar),
        .re_bar     (re_bar),
        .we_bar     (we_bar),
        .mem_rdy    (rdy0),
        .bus_err    (err0),
        .access_cnt (cnt0)
    );

    mem_bus_responder #(
        .WAIT_STATES (3)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .MAddr      (maddr),
        .MData      (md1),
        .ram_en_bar (en1_bar),
        .re_bar     (re_bar),
        .we_bar     (we_bar),
        .mem_rdy    (rdy1),
        .bus_err    (err1),
        .access_cnt (cnt1)
    );

    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [7:0] md_of(input int sel);
        return (sel == 0) ? md0 : md1;
    endfunction

    task automatic release_bus();
        re_bar  = 1'b1;
        we_bar  = 1'b1;
        en0_bar = 1'b1;
        en1_bar = 1'b1;
        wr_oe   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One access; lat = edge count until mem_rdy seen (0 if it never came).
    task automatic bus_access(input int sel, input logic [7:0] addr, input bit wr,
                              input logic [7:0] wdata, input int max_cyc,
                              output int lat, output logic [7:0] rdata);
        lat     = 0;
        rdata   = 8'h00;
        maddr   = addr;
        re_bar  = wr;
        we_bar  = ~wr;
        wr_oe   = wr;
        wr_data = wdata;
        if (sel == 0) en0_bar = 1'b0;
        else          en1_bar = 1'b0;
        for (int i = 0; i < max_cyc && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (rdy_of(sel)) begin
                lat   = i + 1;
                rdata = md_of(sel);
            end
        end
        release_bus();
    endtask

    task automatic test_reset();
        rst = 1'b1; maddr = 8'h00; re_bar = 1'b1; we_bar = 1'b1;
        en0_bar = 1'b1; en1_bar = 1'b1; wr_oe = 1'b0; wr_data = 8'h00;
        cnt_exp0 = 8'd0; cnt_exp1 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL rst_rdy0 got %b want 0", rdy0); end
        n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL rst_err0 got %b want 0", err0); end
        n_vec++; if (cnt0 !== 8'd0) begin n_err++; $display("FAIL rst_cnt0 got %h want 00", cnt0); end
        n_vec++; if (md0 !== 8'hFF) begin n_err++; $display("FAIL rst_md0 got %h want released", md0); end
        n_vec++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL rst_rdy1 got %b want 0", rdy1); end
        n_vec++; if (cnt1 !== 8'd0) begin n_err++; $display("FAIL rst_cnt1 got %h want 00", cnt1); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int         lat;
        logic [7:0] rd, exp;
        logic [7:0] addrs [3];
        logic [7:0] datas [3];
        bus_access(0, 8'h83, 1'b1, 8'h5A, 8, lat, rd);
        model0[8'h83] = 8'h5A; cnt_exp0++;
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL wr_latency got %0d want 2", lat); end
        n_vec++; if (cnt0 !== cnt_exp0) begin n_err++; $display("FAIL wr_cnt got %h want %h", cnt0, cnt_exp0); end
        exp_q.push_back(model0[8'h83]);
        bus_access(0, 8'h83, 1'b0, 8'h00, 8, lat, rd);
        cnt_exp0++;
        exp = exp_q.pop_front();
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL rd_latency got %0d want 2", lat); end
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL rd_data got %h want %h", rd, exp); end
        n_vec++; if (cnt0 !== 8'd2) begin n_err++; $display("FAIL rd_cnt got %h want 02", cnt0); end
        n_vec++; if (md0 !== 8'hFF) begin n_err++; $display("FAIL rd_release got %h want released", md0); end
        addrs = '{8'h80, 8'hFF, 8'hC7};
        datas = '{8'hA5, 8'h3C, 8'h0F};
        for (int i = 0; i < 3; i++) begin
            bus_access(0, addrs[i], 1'b1, datas[i], 8, lat, rd);
            model0[addrs[i]] = datas[i]; cnt_exp0++;
            n_vec++; if (lat != 2) begin n_err++; $display("FAIL wr_edge_lat[%0d] got %0d want 2", i, lat); end
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model0[addrs[i]]);
            bus_access(0, addrs[i], 1'b0, 8'h00, 8, lat, rd);
            cnt_exp0++;
            exp = exp_q.pop_front();
            n_vec++; if (rd !== exp || lat != 2) begin
                n_err++; $display("FAIL rd_edge[%0d] got %h/lat %0d want %h/lat 2", i, rd, lat, exp);
            end
        end
        n_vec++; if (cnt0 !== cnt_exp0) begin n_err++; $display("FAIL wr_rd_cnt got %h want %h", cnt0, cnt_exp0); end
    endtask

    task automatic test_out_of_window();
        int         lat;
        logic [7:0] rd;
        maddr = 8'h10; re_bar = 1'b0; en0_bar = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_vec++; if (rdy0 !== 1'b0 || err0 !== 1'b0) begin
                n_err++; $display("FAIL rom_rdy[%0d] got rdy %b err %b want 0 0", i, rdy0, err0);
            end
            n_vec++; if (md0 !== 8'hFF) begin n_err++; $display("FAIL rom_md[%0d] got %h want released", i, md0); end
        end
        release_bus();
        bus_access(0, 8'h7F, 1'b1, 8'h11, 4, lat, rd);
        n_vec++; if (lat != 0) begin n_err++; $display("FAIL rom_wr_rdy got lat %0d want none", lat); end
        n_vec++; if (cnt0 !== cnt_exp0) begin n_err++; $display("FAIL rom_cnt got %h want %h", cnt0, cnt_exp0); end
    endtask

    task automatic test_bus_err();
        int         lat;
        logic [7:0] rd, exp;
        bus_access(0, 8'h90, 1'b1, 8'h66, 8, lat, rd);
        model0[8'h90] = 8'h66; cnt_exp0++;
        maddr = 8'h90; re_bar = 1'b0; we_bar = 1'b0; wr_oe = 1'b1; wr_data = 8'h99; en0_bar = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (err0 !== 1'b1 || rdy0 !== 1'b0) begin
            n_err++; $display("FAIL err_pulse got err %b rdy %b want 1 0", err0, rdy0);
        end
        @(posedge clk);
        #1;
        n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL err_width got %b want 0", err0); end
        release_bus();
        n_vec++; if (cnt0 !== cnt_exp0) begin n_err++; $display("FAIL err_cnt got %h want %h", cnt0, cnt_exp0); end
        exp_q.push_back(model0[8'h90]);
        bus_access(0, 8'h90, 1'b0, 8'h00, 8, lat, rd);
        cnt_exp0++;
        exp = exp_q.pop_front();
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL err_nowrite got %h want %h", rd, exp); end
    endtask

    task automatic test_abort();
        int         lat, rises;
        logic       prev;
        logic [7:0] rd, exp, got;
        bus_access(1, 8'h85, 1'b1, 8'h42, 10, lat, rd);
        model1[8'h85] = 8'h42; cnt_exp1++;
        n_vec++; if (lat != 4) begin n_err++; $display("FAIL ws3_latency got %0d want 4", lat); end
        maddr = 8'h85; we_bar = 1'b0; wr_oe = 1'b1; wr_data = 8'h77; en1_bar = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_vec++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL abort_rdy[%0d] got %b want 0", i, rdy1); end
        end
        release_bus();
        n_vec++; if (cnt1 !== cnt_exp1) begin n_err++; $display("FAIL abort_cnt got %h want %h", cnt1, cnt_exp1); end
        exp_q.push_back(model1[8'h85]);
        maddr = 8'h85; re_bar = 1'b0; en1_bar = 1'b0;
        rises = 0; prev = 1'b0; got = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rdy1 && !prev) rises++;
            if (rdy1) got = md1;
            prev = rdy1;
        end
        release_bus();
        cnt_exp1++;
        exp = exp_q.pop_front();
        n_vec++; if (rises != 1) begin n_err++; $display("FAIL held_completions got %0d want 1", rises); end
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL held_data got %h want %h", got, exp); end
        n_vec++; if (cnt1 !== cnt_exp1) begin n_err++; $display("FAIL held_cnt got %h want %h", cnt1, cnt_exp1); end
    endtask

    task automatic test_reset_mid();
        int         lat;
        logic [7:0] rd, exp;
        maddr = 8'h83; re_bar = 1'b0; en0_bar = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (rdy0 !== 1'b1 || md0 !== model0[8'h83]) begin
            n_err++; $display("FAIL pre_rst_drive got rdy %b md %h want 1 %h", rdy0, md0, model0[8'h83]);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (md0 !== 8'hFF) begin n_err++; $display("FAIL rst_mid_md got %h want released", md0); end
        n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_rdy got %b want 0", rdy0); end
        n_vec++; if (cnt0 !== 8'd0) begin n_err++; $display("FAIL rst_mid_cnt got %h want 00", cnt0); end
        re_bar = 1'b1; en0_bar = 1'b1;
        @(negedge clk);
        rst = 1'b0; cnt_exp0 = 8'd0; cnt_exp1 = 8'd0;
        @(posedge clk);
        #1;
        // Write interrupted in the wait state must be discarded.
        maddr = 8'h83; we_bar = 1'b0; wr_oe = 1'b1; wr_data = 8'hEE; en0_bar = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        we_bar = 1'b1; en0_bar = 1'b1; wr_oe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(model0[8'h83]);
        bus_access(0, 8'h83, 1'b0, 8'h00, 8, lat, rd);
        cnt_exp0++;
        exp = exp_q.pop_front();
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL rst_keep_data got %h want %h", rd, exp); end
        n_vec++; if (cnt0 !== cnt_exp0) begin n_err++; $display("FAIL rst_recount got %h want %h", cnt0, cnt_exp0); end
    endtask

    task automatic test_back_to_back();
        int         lat;
        logic [7:0] rd, exp, a;
        for (int i = 0; cnt_exp0 != 8'd255; i++) begin
            a = 8'hA0 + 8'(i % 16);
            bus_access(0, a, 1'b1, 8'(i * 7 + 3), 8, lat, rd);
            model0[a] = 8'(i * 7 + 3); cnt_exp0++;
            n_vec++; if (lat != 2) begin n_err++; $display("FAIL b2b_wr[%0d] lat %0d want 2", i, lat); end
        end
        n_vec++; if (cnt0 !== 8'd255) begin n_err++; $display("FAIL cnt_max got %h want ff", cnt0); end
        for (int i = 0; i < 16; i++) begin
            a = 8'hA0 + 8'(i);
            exp_q.push_back(model0[a]);
            bus_access(0, a, 1'b0, 8'h00, 8, lat, rd);
            cnt_exp0++;
            exp = exp_q.pop_front();
            n_vec++; if (rd !== exp) begin n_err++; $display("FAIL b2b_rd[%0d] got %h want %h", i, rd, exp); end
            if (i == 0) begin
                n_vec++; if (cnt0 !== 8'd0) begin n_err++; $display("FAIL cnt_wrap got %h want 00", cnt0); end
            end
        end
        n_vec++; if (cnt0 !== cnt_exp0) begin n_err++; $display("FAIL cnt_final got %h want %h", cnt0, cnt_exp0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_window();
        test_bus_err();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Responder end of the processor memory bus: decodes the processor's `ram_en_bar`/`re_bar`/`we_bar` strobes and `MAddr`, serves reads by driving the shared `MData` bus and commits writes into an internal data RAM. It occupies the upper address window, leaving the lower window to the program ROM. It adds programmable wait states, a ready handshake, illegal-access detection and an access counter.

## Interface
- `DATA_W`, 8, data bus width
- `ADDR_W`, 8, address bus width
- `DEPTH`, 128, RAM words
- `RAM_BASE`, 8'h80, first address of the RAM window; window is `RAM_BASE`..`RAM_BASE+DEPTH-1`
- `WAIT_STATES`, 1, extra cycles before completion, legal 0..3
- `clk`  in  1  clock, all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `MAddr`  in  8  bus address from processor
- `MData`  inout  8  shared data bus, driven only during read completion
- `ram_en_bar`  in  1  RAM select, active-low
- `re_bar`  in  1  read strobe, active-low
- `we_bar`  in  1  write strobe, active-low
- `mem_rdy`  out  1  access complete: read data valid on `MData` / write committed
- `bus_err`  out  1  one-cycle pulse on illegal access
- `access_cnt`  out  8  count of completed in-window accesses

## Operation
- Access request: `ram_en_bar`=0 and `MAddr` inside window. Out-of-window requests ignored (no drive, no rdy, no err, no count).
- FSM states: IDLE, WAIT, RDRIVE, WDONE, ERR.
- IDLE: on request with `re_bar`=0,`we_bar`=1 → capture address (offset `MAddr-RAM_BASE`), dir=read; with `we_bar`=0,`re_bar`=1 → capture address and `MData`, dir=write. Go to WAIT if `WAIT_STATES`>0, else directly RDRIVE/WDONE.
- Request with both strobes low → ERR; `bus_err`=1 for that one cycle; no memory change, no count.
- WAIT: counts `WAIT_STATES` cycles, then RDRIVE (read) or WDONE (write; array written at the transition edge from captured address/data).
- RDRIVE: `MData` = array[captured address]; `mem_rdy`=1.
- WDONE: `mem_rdy`=1.
- RDRIVE/WDONE/ERR exit to IDLE when `ram_en_bar`=1 or the active strobe returns high; `access_cnt` increments on RDRIVE/WDONE exit, wraps 255→0.
- One access per strobe assertion: held strobes never start a second access.
- `MAddr`/`MData` changes after capture are ignored for the rest of the access.
- Strobe released during WAIT: access aborted → IDLE, no write, no count.
- `MData` output enable = (state==RDRIVE) & ~`ram_en_bar` & ~`re_bar` (combinational), otherwise high-Z.

## Timing
- Reset values: state IDLE, `mem_rdy`=0, `bus_err`=0, `access_cnt`=0, `MData` high-Z, wait counter 0. RAM contents not cleared.
- Reset asserted mid-access: bus released and outputs at reset values immediately (asynchronously); pending write discarded.
- Request sampled at edge k: `mem_rdy` rises after edge k+`WAIT_STATES`; `WAIT_STATES`=0 gives rdy after edge k.
- Write array update occurs at the same edge that raises `mem_rdy`.
- `MData` released combinationally when strobe deasserts; state returns to IDLE at next edge; earliest new access sampled one edge after that (one-cycle turnaround).

## Structure
- Shared package `mem_bus_pkg`: FSM state enum, `DATA_W`/`ADDR_W` defaults, `RAM_BASE` default, `MAX_WAIT`=3.
- One sub-module `mem_bus_ram_array`: `DEPTH`×`DATA_W`, synchronous write port, combinational read port.
- FSM, wait counter, capture registers, tristate and counter in the top module.

## Test plan
- Reset then write 8'h5A to 8'h83 (`WAIT_STATES`=1) → `mem_rdy` after 2nd edge; read 8'h83 → `MData`=8'h5A with `mem_rdy`, `access_cnt`=2.
- Read from 8'h10 (ROM window) → `MData` high-Z, `mem_rdy`=0, `access_cnt` unchanged.
- Both `re_bar`/`we_bar` low at 8'h90 → `bus_err` one-cycle pulse; subsequent read of 8'h90 returns prior contents.
- `WAIT_STATES`=3, read strobe released after 2 cycles → no `mem_rdy`, no count; strobe held 6 cycles → single completion, count +1.
- `rst` pulsed during RDRIVE → `MData` high-Z and `mem_rdy`=0 immediately; previously written data still readable.
- 256 completed accesses → `access_cnt` wraps to 0.
